alu_accumulator: RTL and testbench
==================================

Name: alu_accumulator

Overview:
- Sequential stage directly downstream of the 4-bit ALU datapath.
- Owns an 8-bit accumulator register that captures each ALU result.
- Feeds the accumulator's low nibble back as operand B, so chained operations run without re-entering switches.
- Adds a valid/ready operation handshake and a 4-cycle shift-add multiplier; sits between switch/key input logic and the LEDR/HEX display drivers.

Parameters:
- MUL_CYCLES, 4, iterations of the shift-add multiplier; fixed at 4 for 4-bit operands, other values unsupported.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- op_valid  input  1  operation request.
- op_ready  output  1  block can accept an operation this cycle.
- func  input  3  operation select, sampled on accept.
- a  input  4  operand A, sampled on accept.
- acc  output  8  accumulator value.
- carry  output  1  carry flag of the last operation.
- result_valid  output  1  one-cycle pulse: acc holds a new result.
- busy  output  1  multiplier in progress.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: acc=8'h00, carry=0, result_valid=0, busy=0, op_ready=1, state=IDLE.
- B = acc[3:0], sampled at the accept edge.
- Accept = op_valid & op_ready at a rising edge. op_valid while op_ready=0 is ignored, not queued.
- States:
  - IDLE: op_ready=1, busy=0. Accept with func!=6 keeps IDLE. Accept with func=6 goes to MUL.
  - MUL: op_ready=0, busy=1, for exactly MUL_CYCLES cycles, then back to IDLE.
- Single-cycle ops: acc written on the accept edge; result_valid=1 for the following cycle only.
- func encoding (result written to acc):
  - 0: {4'b0,a} + {4'b0,B}; max 8'd30; carry=0.
  - 1: acc + {4'b0,a}; 8-bit wrap; carry = bit 8 of the 9-bit sum.
  - 2: {a|B, a^B}; carry=0.
  - 3: 8'd1 if any bit of {a,B} set, else 8'd0; carry=0.
  - 4: 8'd1 if all bits of {a,B} set, else 8'd0; carry=0.
  - 5: {a,B}; carry=0.
  - 6: a*B, unsigned 8-bit product, no overflow possible; carry=0.
  - 7: acc << a[2:0], zero fill, bits shifted out lost; carry=0.
- Multiply:
  - At the accept edge, latch multiplicand a and multiplier B into internal registers; zero the partial product; acc unchanged.
  - Each MUL cycle adds the multiplicand, shifted by the iteration index, when the corresponding multiplier bit is 1.
  - Final product written to acc at the edge ending MUL cycle 4; result_valid=1 in the next cycle (IDLE).
  - The block accepts a new op in that same cycle.
  - acc holds its old value throughout MUL.
  - Accept-to-result_valid latency: 5 cycles; op_ready low for exactly 4 cycles.
- Back-to-back single-cycle ops: one accepted per cycle; each uses the acc produced by the previous edge; result_valid stays high continuously.
- Reset mid-MUL: abort, all outputs to reset values, no result_valid pulse, partial product discarded.
- Reset and op_valid in the same cycle: reset wins, op dropped.
- carry changes only on accepted ops (for func=6, at the write edge).

Optional Feature:
- Macro: ALU_ACCUMULATOR_HEX_EN.
- When defined:
  - Adds output ports hex_lo [6:0] and hex_hi [6:0].
  - Combinational 7-segment decode of acc[3:0] and acc[7:4]: active-low, bit0=segment a through bit6=segment g, full 0-F glyphs.
  - Reset state shows "00" (7'b1000000 each).
- When undefined: ports and decode logic absent; all other behaviour identical.

Test Plan:
- Reset held 2 cycles then released -> acc=8'h00, carry=0, result_valid=0, op_ready=1, busy=0.
- acc=8'h03, accept func=5, a=4'hA -> next cycle acc=8'hA3, result_valid=1 for exactly one cycle.
- acc=8'hFE, accept func=1, a=4'h5 -> acc=8'h03, carry=1; then func=0, a=4'h1 -> acc=8'h04, carry=0.
- acc=8'h0D, accept func=6, a=4'hB; hold op_valid high with func=5 throughout -> op_ready=0 and busy=1 for exactly 4 cycles, acc=8'h0D during them, then acc=8'h8F with result_valid pulse; the func=5 op is accepted only in the following IDLE cycle.
- acc=8'h0D, func=6 accepted, reset asserted in second MUL cycle -> next cycle acc=8'h00, IDLE, op_ready=1, no result_valid.
- acc=8'h0F, func=4, a=4'hF -> acc=8'h01; then func=3, a=4'h0 -> acc=8'h01; then func=7, a=4'h3 -> acc=8'h08; with ALU_ACCUMULATOR_HEX_EN defined, acc=8'h1E -> hex_hi=7'b1111001, hex_lo=7'b0000110.

Source files
------------

// File: rtl/alu_accumulator.sv
// alu_accumulator: 8-bit accumulator stage behind the 4-bit ALU datapath.
// Operand B is always the accumulator's low nibble. Single-cycle ops commit on
// the accept edge. func=6 runs a MUL_CYCLES-iteration shift-add multiply.
// Optional build macro: ALU_ACCUMULATOR_HEX_EN adds a two-digit active-low
// 7-segment decode of acc on hex_lo / hex_hi.
module alu_accumulator #(
  parameter int MUL_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [2:0] func,
  input  logic [3:0] a,
  output logic [7:0] acc,
  output logic       carry,
  output logic       result_valid,
  output logic       busy
`ifdef ALU_ACCUMULATOR_HEX_EN
  ,
  output logic [6:0] hex_lo,
  output logic [6:0] hex_hi
`endif
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [2:0] FUNC_MUL = 3'd6;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       mcand_q, mcand_d;
  logic [3:0]       mplier_q, mplier_d;
  logic [7:0]       prod_q, prod_d;
  logic [7:0]       acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             rv_q, rv_d;

  logic [3:0] b;
  logic       accept;
  logic [7:0] alu_res;
  logic       alu_c;
  logic [8:0] sum9;
  logic [7:0] addend;

  assign b      = acc_q[3:0];
  assign accept = op_valid & op_ready;
  assign sum9   = {1'b0, acc_q} + {5'b0, a};
  // Partial-product term for the current iteration: multiplicand shifted by the
  // iteration index, gated by the matching multiplier bit.
  assign addend = mplier_q[cnt_q] ? ({4'b0, mcand_q} << cnt_q) : 8'h00;

  // Single-cycle ALU result from operand a and the fed-back low nibble.
  always_comb begin
    alu_res = 8'h00;
    alu_c   = 1'b0;
    unique case (func)
      3'd0: alu_res = {4'b0, a} + {4'b0, b};
      3'd1: begin
        alu_res = sum9[7:0];
        alu_c   = sum9[8];
      end
      3'd2: alu_res = {a | b, a ^ b};
      3'd3: alu_res = {7'b0, |{a, b}};
      3'd4: alu_res = {7'b0, &{a, b}};
      3'd5: alu_res = {a, b};
      // Multiply never commits through this path; the FSM handles it.
      3'd6: alu_res = 8'h00;
      3'd7: alu_res = acc_q << a[2:0];
      default: alu_res = 8'h00;
    endcase
  end

  // Next-state and handshake outputs: IDLE accepts, MUL iterates the product.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    rv_d     = 1'b0;
    op_ready = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        op_ready = 1'b1;
        if (accept) begin
          if (func == FUNC_MUL) begin
            state_d  = S_MUL;
            cnt_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            prod_d   = 8'h00;
          end else begin
            acc_d   = alu_res;
            carry_d = alu_c;
            rv_d    = 1'b1;
          end
        end
      end
      S_MUL: begin
        busy   = 1'b1;
        prod_d = prod_q + addend;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // 4x4 product fits in 8 bits, so carry is always cleared here.
          acc_d   = prod_q + addend;
          carry_d = 1'b0;
          rv_d    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; synchronous reset also drops any in-flight multiply.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= 4'h0;
      mplier_q <= 4'h0;
      prod_q   <= 8'h00;
      acc_q    <= 8'h00;
      carry_q  <= 1'b0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      rv_q     <= rv_d;
    end
  end

  assign acc          = acc_q;
  assign carry        = carry_q;
  assign result_valid = rv_q;

`ifdef ALU_ACCUMULATOR_HEX_EN
  // Active-low segments, bit0 = a ... bit6 = g.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign hex_lo = seg7(acc_q[3:0]);
  assign hex_hi = seg7(acc_q[7:4]);
`endif

endmodule

// File: tb/tb_alu_accumulator.sv
// Directed bench for alu_accumulator with an expected-result scoreboard.
module tb_alu_accumulator;

  logic       clk = 1'b0;
  logic       reset;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] func;
  logic [3:0] a;
  logic [7:0] acc;
  logic       carry;
  logic       result_valid;
  logic       busy;
`ifdef ALU_ACCUMULATOR_HEX_EN
  logic [6:0] hex_lo, hex_hi;
`endif

  alu_accumulator #(.MUL_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .func(func), .a(a), .acc(acc), .carry(carry),
    .result_valid(result_valid), .busy(busy)
`ifdef ALU_ACCUMULATOR_HEX_EN
    , .hex_lo(hex_lo), .hex_hi(hex_hi)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] acc;
    logic       c;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] m_acc;
  logic       m_c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour of one accepted op on the model accumulator.
  task automatic model(input logic [2:0] f, input logic [3:0] av);
    logic [3:0] bv;
    int r;
    bv = m_acc[3:0];
    m_c = 1'b0;
    case (f)
      3'd0: m_acc = 8'(int'(av) + int'(bv));
      3'd1: begin
        r = int'(m_acc) + int'(av);
        m_acc = 8'(r % 256);
        m_c = (r > 255);
      end
      3'd2: m_acc = {av | bv, av ^ bv};
      3'd3: m_acc = ({av, bv} != 8'h00) ? 8'd1 : 8'd0;
      3'd4: m_acc = ({av, bv} == 8'hFF) ? 8'd1 : 8'd0;
      3'd5: m_acc = {av, bv};
      3'd6: m_acc = 8'(int'(av) * int'(bv));
      default: m_acc = 8'((int'(m_acc) << av[2:0]) % 256);
    endcase
  endtask

  // Present an op for acceptance and record its expected result.
  task automatic issue(input logic [2:0] f, input logic [3:0] av);
    op_valid = 1'b1;
    func = f;
    a = av;
    model(f, av);
    sb.push_back('{acc: m_acc, c: m_c});
  endtask

  // Wait (bounded) for result_valid and check against the oldest expectation.
  task automatic collect(input string tag);
    exp_t e;
    int k = 0;
    while (result_valid !== 1'b1 && k < 10) begin
      step();
      k++;
    end
    chk({tag, "_rv"}, 32'(result_valid), 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_acc"}, 32'(acc), 32'(e.acc));
      chk({tag, "_carry"}, 32'(carry), 32'(e.c));
    end
  endtask

  task automatic op(input string tag, input logic [2:0] f, input logic [3:0] av);
    issue(f, av);
    step();
    op_valid = 1'b0;
    collect(tag);
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; func = 3'd0; a = 4'h0;
    m_acc = 8'h00; m_c = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_acc", 32'(acc), 32'h00);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_rv", 32'(result_valid), 32'd0);
    chk("rst_ready", 32'(op_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
`ifdef ALU_ACCUMULATOR_HEX_EN
    chk("rst_hex_lo", 32'(hex_lo), 32'h40);
    chk("rst_hex_hi", 32'(hex_hi), 32'h40);
`endif

    // acc=03, then func5 a=A -> A3 with a single-cycle pulse
    op("set03", 3'd0, 4'h3);
    op("cat_A3", 3'd5, 4'hA);
    chk("cat_A3_val", 32'(acc), 32'hA3);
    step();
    chk("rv_one_cycle", 32'(result_valid), 32'd0);

    // build FE, then add with carry out, then func0 clears carry
    op("set0E", 3'd0, 4'hB);
    op("setFE", 3'd5, 4'hF);
    op("add_wrap", 3'd1, 4'h5);
    chk("add_wrap_val", 32'(acc), 32'h03);
    chk("add_wrap_c", 32'(carry), 32'd1);
    op("add_nib", 3'd0, 4'h1);
    chk("add_nib_val", 32'(acc), 32'h04);
    chk("add_nib_c", 32'(carry), 32'd0);

    // acc=0D then multiply by B with a held-off func5 request
    op("set0D", 3'd0, 4'h9);
    issue(3'd6, 4'hB);
    step();
    issue(3'd5, 4'h2);
    sb.pop_back();          // re-pushed below once the model holds the product
    m_acc = 8'h0D;
    for (int i = 0; i < 4; i++) begin
      chk("mul_ready_lo", 32'(op_ready), 32'd0);
      chk("mul_busy", 32'(busy), 32'd1);
      chk("mul_acc_hold", 32'(acc), 32'h0D);
      chk("mul_rv_lo", 32'(result_valid), 32'd0);
      step();
    end
    chk("mul_ready_back", 32'(op_ready), 32'd1);
    chk("mul_busy_done", 32'(busy), 32'd0);
    m_acc = 8'h8F; m_c = 1'b0;
    collect("mul_res");
    chk("mul_val", 32'(acc), 32'h8F);
    model(3'd5, 4'h2);
    sb.push_back('{acc: m_acc, c: m_c});
    step();
    op_valid = 1'b0;
    collect("after_mul");
    chk("after_mul_val", 32'(acc), 32'h2F);

    // back-to-back single-cycle ops keep result_valid high
    issue(3'd3, 4'h0);
    step();
    collect("b2b_1");
    issue(3'd0, 4'hC);
    step();
    op_valid = 1'b0;
    collect("b2b_2");
    chk("b2b_val", 32'(acc), 32'h0D);

    // reset in the second MUL cycle aborts the multiply
    issue(3'd6, 4'hB);
    void'(sb.pop_back());
    step();
    op_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_acc = 8'h00; m_c = 1'b0;
    chk("abort_acc", 32'(acc), 32'h00);
    chk("abort_ready", 32'(op_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rv", 32'(result_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("abort_no_rv", 32'(result_valid), 32'd0);
    end

    // reset wins over a simultaneous op
    reset = 1'b1;
    op_valid = 1'b1; func = 3'd0; a = 4'h5;
    step();
    reset = 1'b0; op_valid = 1'b0;
    chk("rst_wins_acc", 32'(acc), 32'h00);
    chk("rst_wins_rv", 32'(result_valid), 32'd0);

    // logic, shift, and nibble-pack ops
    op("set0F", 3'd0, 4'hF);
    op("all_F", 3'd4, 4'hF);
    chk("all_F_val", 32'(acc), 32'h01);
    op("any_0", 3'd3, 4'h0);
    chk("any_0_val", 32'(acc), 32'h01);
    op("shl3", 3'd7, 4'h3);
    chk("shl3_val", 32'(acc), 32'h08);
    op("orxor", 3'd2, 4'h5);
    chk("orxor_val", 32'(acc), 32'hDD);
    op("shl1", 3'd7, 4'h9);
    chk("shl1_val", 32'(acc), 32'hBA);
    op("mul2", 3'd6, 4'h7);
    chk("mul2_val", 32'(acc), 32'h46);
    op("to01", 3'd3, 4'h0);
    op("to0E", 3'd0, 4'hD);
    op("to1E", 3'd5, 4'h1);
    chk("to1E_val", 32'(acc), 32'h1E);
`ifdef ALU_ACCUMULATOR_HEX_EN
    chk("hex_hi_1", 32'(hex_hi), 32'b1111001);
    chk("hex_lo_E", 32'(hex_lo), 32'b0000110);
`endif
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
